// File: rtl/xnor_dot_sequencer.sv
// xnor_dot_sequencer: streams TP-bit operand chunks through one XNOR-popcount PE and
// accumulates the signed per-chunk results into a (matches - mismatches) dot product.
module xnor_dot_sequencer #(
  parameter  int TP      = 8,
  parameter  int MAX_LEN = 256,
  localparam int NCH     = MAX_LEN / TP,
  localparam int AW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW      = $clog2(MAX_LEN) + 1,
  // one extra bit so an all-match chunk (+TP) is representable next to -TP
  localparam int PW      = $clog2(TP) + 2,
  localparam int RW      = LW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LW-1:0]        len_i,
  output logic                 busy_o,
  output logic                 rd_en_o,
  output logic [AW-1:0]        rd_addr_o,
  input  logic [TP-1:0]        rd_data1_i,
  input  logic [TP-1:0]        rd_data2_i,
  output logic [TP-1:0]        pe_data1_o,
  output logic [TP-1:0]        pe_data2_o,
  output logic [TP-1:0]        pe_mask_o,
  input  logic signed [PW-1:0] pe_result_i,
  output logic signed [RW-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i
);
  localparam int LT = $clog2(TP);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t               r_state, w_next;
  logic [AW-1:0]        r_addr, r_last;
  logic [LT-1:0]        r_rem;
  logic [TP-1:0]        r_mask;
  logic                 r_acc_en, r_tail;
  logic signed [RW-1:0] r_acc, w_inc;
  logic [LW-1:0]        w_len, w_lm1;
  logic                 w_is_last, w_start;
  assign w_len     = (len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_i;
  assign w_lm1     = w_len - LW'(1);
  assign w_is_last = r_addr == r_last;
  assign w_start   = r_state == IDLE && start_i;
  // masked lanes come back from the PE as -1 each; the tail term cancels them
  assign w_inc     = RW'(pe_result_i) + (r_tail ? RW'(TP) - RW'(r_rem) : RW'(0));
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !start_i ? IDLE : (w_len == '0) ? DONE : RUN;
      RUN:     w_next = w_is_last ? DRAIN : RUN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = result_ready_i ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_last   <= '0;
      r_rem    <= '0;
      r_mask   <= '0;
      r_acc_en <= 1'b0;
      r_tail   <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_addr   <= (r_state == RUN && !w_is_last) ? r_addr + AW'(1) : '0;
      r_mask   <= (r_state != RUN) ? '0 :
                  (w_is_last && r_rem != '0) ? ~({TP{1'b1}} << r_rem) : '1;
      r_acc_en <= r_state == RUN;
      r_tail   <= r_state == RUN && w_is_last && r_rem != '0;
      r_acc    <= w_start ? '0 : r_acc_en ? r_acc + w_inc : r_acc;
      if (w_start) begin
        r_last <= AW'(w_lm1 >> LT);
        r_rem  <= w_len[LT-1:0];
      end
    end
  end
  assign busy_o         = r_state != IDLE;
  assign rd_en_o        = r_state == RUN;
  assign rd_addr_o      = r_addr;
  assign pe_mask_o      = r_mask;
  assign pe_data1_o     = r_acc_en ? rd_data1_i : '0;
  assign pe_data2_o     = r_acc_en ? rd_data2_i : '0;
  assign result_valid_o = r_state == DONE;
  assign result_o       = result_valid_o ? r_acc : '0;
endmodule

// File: tb/tb_xnor_dot_sequencer.sv
// tb_xnor_dot_sequencer: random and directed jobs against a bit-level dot-product model,
// with a memory and PE model around the DUT.
module tb_xnor_dot_sequencer;
  logic              clk = 0, rst_n = 0, start = 0, ready = 0;
  logic [8:0]        len = '0;
  logic              busy, rd_en, valid;
  logic [4:0]        rd_addr;
  logic [7:0]        rd_d1 = '0, rd_d2 = '0, pe_d1, pe_d2, pe_mask;
  logic signed [4:0] pe_res;
  logic signed [9:0] result;
  logic [7:0]        mem_a [32];
  logic [7:0]        mem_b [32];
  int                errors = 0, checks = 0, lit_mask = -1;

  always #5 clk = ~clk;

  xnor_dot_sequencer #(.TP(8), .MAX_LEN(256)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .busy_o(busy),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data1_i(rd_d1), .rd_data2_i(rd_d2),
    .pe_data1_o(pe_d1), .pe_data2_o(pe_d2), .pe_mask_o(pe_mask), .pe_result_i(pe_res),
    .result_o(result), .result_valid_o(valid), .result_ready_i(ready)
  );

  always @(posedge clk) if (rd_en) begin
    rd_d1 <= mem_a[rd_addr];
    rd_d2 <= mem_b[rd_addr];
  end

  always_comb pe_res = 5'(2 * $countones(pe_mask & ~(pe_d1 ^ pe_d2)) - 8);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model(input int l);
    int s = 0;
    for (int i = 0; i < l; i++) s += (mem_a[i/8][i%8] == mem_b[i/8][i%8]) ? 1 : -1;
    return s;
  endfunction

  task automatic fill(input int mode, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = (mode == 0) ? a : 8'($urandom);
      mem_b[i] = (mode == 0) ? b : (mode == 1) ? ~mem_a[i] : 8'($urandom);
    end
  endtask

  // entered and left just after a rising edge, with the DUT idle
  task automatic run_job(input int ln, input int dly, input bit sid, input bit use_lit, input int lit);
    int l, n, r, exp, vk, em;
    bit er;
    l = (ln > 256) ? 256 : ln;
    n = (l + 7) / 8;
    r = l % 8;
    exp = model(l);
    if (use_lit) chk("model_pin", exp, lit);
    vk = (l > 0) ? n + 2 : 1;
    start = 1;
    len = 9'(ln);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    @(posedge clk); #1;
    start = 0;
    for (int k = 1; k <= vk + dly; k++) begin
      if (k >= vk) begin
        ready = (k == vk + dly);
        start = sid && !ready;
        len = 9'($urandom_range(1, 300));
      end
      @(negedge clk);
      er = l > 0 && k <= n;
      em = (l > 0 && k >= 2 && k <= n + 1) ? ((k == n + 1 && r != 0) ? (1 << r) - 1 : 255) : 0;
      chk("busy", int'(busy), 1);
      chk("rd_en", int'(rd_en), int'(er));
      chk("rd_addr", int'(rd_addr), er ? k - 1 : 0);
      chk("pe_mask", int'(pe_mask), em);
      if (lit_mask >= 0 && k == n + 1) chk("pe_mask_lit", int'(pe_mask), lit_mask);
      chk("valid", int'(valid), int'(k >= vk));
      if (k >= vk) chk("result", int'(result), exp);
      if (use_lit && k >= vk) chk("result_lit", int'(result), lit);
      @(posedge clk); #1;
    end
    ready = 0;
    start = 0;
    @(negedge clk);
    chk("post_busy", int'(busy), 0);
    chk("post_valid", int'(valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_rd_en"}, int'(rd_en), 0);
    chk({nm, "_addr"}, int'(rd_addr), 0);
    chk({nm, "_mask"}, int'(pe_mask), 0);
    chk({nm, "_data"}, int'({pe_d1, pe_d2}), 0);
    chk({nm, "_valid"}, int'(valid), 0);
    chk({nm, "_result"}, int'(result), 0);
  endtask

  initial begin
    #2;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    fill(0, 8'hA5, 8'hA5);
    run_job(16, 0, 0, 1, 16);
    fill(1, 0, 0);
    run_job(16, 1, 0, 1, -16);
    fill(0, 8'hFF, 8'h07);
    lit_mask = 8'h1F;
    run_job(5, 0, 0, 1, 1);
    lit_mask = -1;
    run_job(0, 2, 1, 1, 0);
    fill(2, 0, 0);
    run_job(256, 5, 1, 0, 0);
    fill(0, 8'h3C, 8'h3C);
    run_job(300, 1, 0, 1, 256);
    fill(2, 0, 0);
    start = 1;
    len = 9'd256;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    run_job(40, 0, 0, 0, 0);
    for (int j = 0; j < 30; j++) begin
      fill(2, 0, 0);
      run_job($urandom_range(0, 300), $urandom_range(0, 3), 1'($urandom), 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
